// File: rtl/fifo_wr_sched_pkg.sv
// Shared definitions for the FIFO write-port scheduler: state encoding,
// counter widths and the position of the end-of-frame flag in a FIFO word.
package fifo_wr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The end-of-frame flag sits directly above the data byte.
  function automatic int last_bit(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/fifo_wr_sched_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer, searching circularly. Returns a one-hot pick and an any-valid flag.
module fifo_wr_sched_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic            o_any
);

  logic [PW:0] w_idx;

  // Walk the requesters starting at the pointer; the first valid one wins.
  always_comb begin
    o_pick = '0;
    o_any  = 1'b0;
    w_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) w_idx = w_idx - (PW+1)'(NREQ);
      if (!o_any && i_valid[w_idx[PW-1:0]]) begin
        o_pick[w_idx[PW-1:0]] = 1'b1;
        o_any                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// Frame-granular round-robin owner of the async FIFO write port. One
// requester streams a whole frame at a time; over-long frames are cut at
// MAXLEN beats and their tail is swallowed until the requester's own last.
module fifo_wr_sched
  import fifo_wr_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int MAXLEN = 1518
) (
  input  logic               wclk,
  input  logic               rrst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic               fifo_winc,
  output logic [DW:0]        fifo_wdata,
  input  logic               fifo_wfull,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   trunc_cnt
);

  localparam int PW       = $clog2(NREQ);
  localparam int LEN_W    = $clog2(MAXLEN+1);
  localparam int LAST_BIT = last_bit(DW);
  localparam logic [LEN_W-1:0] LEN_TOP = LEN_W'(MAXLEN-1);

  state_e            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_grant, w_grant_nxt;
  logic [PW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [CNT_W-1:0]  r_frame_cnt, r_trunc_cnt;
  logic              w_frame_inc, w_trunc_inc;

  logic [NREQ-1:0]   w_pick;
  logic              w_any;
  logic [DW-1:0]     w_g_data;
  logic [PW-1:0]     w_g_idx;
  logic [PW-1:0]     w_ptr_inc;
  logic              w_g_valid, w_g_last, w_at_max;

  fifo_wr_sched_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_pick  (w_pick),
    .o_any   (w_any)
  );

  // Select the owner's data byte and index from the one-hot grant.
  always_comb begin
    w_g_data = '0;
    w_g_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_g_data = w_g_data | req_data[i*DW +: DW];
        w_g_idx  = PW'(i);
      end
    end
  end

  assign w_g_valid = |(req_valid & r_grant);
  assign w_g_last  = |(req_last  & r_grant);
  assign w_at_max  = (r_len == LEN_TOP);
  // Explicit wrap so non-power-of-two NREQ never points past the last requester.
  assign w_ptr_inc = (w_g_idx == PW'(NREQ-1)) ? '0 : w_g_idx + 1'b1;

  // Next-state, handshake and FIFO write decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_len_nxt    = r_len;
    w_frame_inc  = 1'b0;
    w_trunc_inc  = 1'b0;
    req_ready    = '0;
    fifo_winc    = 1'b0;
    fifo_wdata   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_len_nxt   = '0;
          w_state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        req_ready            = r_grant & {NREQ{~fifo_wfull}};
        fifo_winc            = w_g_valid & ~fifo_wfull;
        fifo_wdata[DW-1:0]   = w_g_data;
        fifo_wdata[LAST_BIT] = w_g_last | w_at_max;
        if (fifo_winc) begin
          w_len_nxt = r_len + 1'b1;
          if (w_g_last) begin
            w_frame_inc  = 1'b1;
            w_rr_ptr_nxt = w_ptr_inc;
            w_grant_nxt  = '0;
            w_state_nxt  = ST_IDLE;
          end else if (w_at_max) begin
            w_frame_inc = 1'b1;
            w_trunc_inc = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Tail of a truncated frame: accept and drop, FIFO state is irrelevant.
        req_ready = r_grant;
        if (w_g_valid && w_g_last) begin
          w_rr_ptr_nxt = w_ptr_inc;
          w_grant_nxt  = '0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant, pointer, length and statistics registers.
  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_len       <= '0;
      r_frame_cnt <= '0;
      r_trunc_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_len       <= w_len_nxt;
      r_frame_cnt <= r_frame_cnt + CNT_W'(w_frame_inc);
      if (w_trunc_inc && (r_trunc_cnt != CNT_MAX))
        r_trunc_cnt <= r_trunc_cnt + 1'b1;
    end
  end

  assign grant     = r_grant;
  assign busy      = (r_state != ST_IDLE);
  assign frame_cnt = r_frame_cnt;
  assign trunc_cnt = r_trunc_cnt;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched: a cycle table on the default build, plus
// hand sequences for round-robin, truncation (MAXLEN=4), NREQ=3 wrap and reset.
module tb_fifo_wr_sched;

  logic wclk = 1'b0;
  logic rrst_n;
  always #5 wclk = ~wclk;

  // default build: NREQ=4, MAXLEN=1518
  logic [3:0]  m_valid, m_last, m_ready, m_grant;
  logic [31:0] m_data;
  logic        m_winc, m_wfull, m_busy;
  logic [8:0]  m_wdata;
  logic [15:0] m_fcnt, m_tcnt;

  // truncation build: NREQ=4, MAXLEN=4
  logic [3:0]  t_valid, t_last, t_ready, t_grant;
  logic [31:0] t_data;
  logic        t_winc, t_wfull, t_busy;
  logic [8:0]  t_wdata;
  logic [15:0] t_fcnt, t_tcnt;

  // three-requester build
  logic [2:0]  n_valid, n_last, n_ready, n_grant;
  logic [23:0] n_data;
  logic        n_winc, n_wfull, n_busy;
  logic [8:0]  n_wdata;
  logic [15:0] n_fcnt, n_tcnt;

  fifo_wr_sched #(.NREQ(4), .DW(8), .MAXLEN(1518)) u_dut (
    .wclk(wclk), .rrst_n(rrst_n), .req_valid(m_valid), .req_data(m_data),
    .req_last(m_last), .req_ready(m_ready), .fifo_winc(m_winc), .fifo_wdata(m_wdata),
    .fifo_wfull(m_wfull), .grant(m_grant), .busy(m_busy), .frame_cnt(m_fcnt),
    .trunc_cnt(m_tcnt));

  fifo_wr_sched #(.NREQ(4), .DW(8), .MAXLEN(4)) u_trn (
    .wclk(wclk), .rrst_n(rrst_n), .req_valid(t_valid), .req_data(t_data),
    .req_last(t_last), .req_ready(t_ready), .fifo_winc(t_winc), .fifo_wdata(t_wdata),
    .fifo_wfull(t_wfull), .grant(t_grant), .busy(t_busy), .frame_cnt(t_fcnt),
    .trunc_cnt(t_tcnt));

  fifo_wr_sched #(.NREQ(3), .DW(8), .MAXLEN(1518)) u_n3 (
    .wclk(wclk), .rrst_n(rrst_n), .req_valid(n_valid), .req_data(n_data),
    .req_last(n_last), .req_ready(n_ready), .fifo_winc(n_winc), .fifo_wdata(n_wdata),
    .fifo_wfull(n_wfull), .grant(n_grant), .busy(n_busy), .frame_cnt(n_fcnt),
    .trunc_cnt(n_tcnt));

  typedef struct {
    logic [3:0]  v, l;
    logic [31:0] d;
    logic        f;
    logic [3:0]  eg, er;
    logic        ew;
    logic [8:0]  ewd;
  } vec_t;

  vec_t tbl[14];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic [3:0] v, l, input logic [31:0] d, input logic f,
                              input logic [3:0] eg, er, input logic ew, input logic [8:0] ewd);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.f = f; r.eg = eg; r.er = er; r.ew = ew; r.ewd = ewd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge wclk);
    #1;
  endtask

  // hard stop in case something upstream wedges
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // req1 4-beat frame, then req3 frame with 3 full cycles
    tbl[0]  = mk(4'b0010, 4'b0000, 32'h0000A100, 0, 4'b0000, 4'b0000, 0, 9'h000);
    tbl[1]  = mk(4'b0010, 4'b0000, 32'h0000A100, 0, 4'b0010, 4'b0010, 1, 9'h0A1);
    tbl[2]  = mk(4'b0010, 4'b0000, 32'h0000A200, 0, 4'b0010, 4'b0010, 1, 9'h0A2);
    tbl[3]  = mk(4'b0010, 4'b0000, 32'h0000A300, 0, 4'b0010, 4'b0010, 1, 9'h0A3);
    tbl[4]  = mk(4'b0010, 4'b0010, 32'h0000A400, 0, 4'b0010, 4'b0010, 1, 9'h1A4);
    tbl[5]  = mk(4'b0000, 4'b0000, 32'h00000000, 0, 4'b0000, 4'b0000, 0, 9'h000);
    tbl[6]  = mk(4'b1000, 4'b0000, 32'hB1000000, 0, 4'b0000, 4'b0000, 0, 9'h000);
    tbl[7]  = mk(4'b1000, 4'b0000, 32'hB1000000, 0, 4'b1000, 4'b1000, 1, 9'h0B1);
    tbl[8]  = mk(4'b1000, 4'b0000, 32'hB2000000, 1, 4'b1000, 4'b0000, 0, 9'h0B2);
    tbl[9]  = mk(4'b1000, 4'b0000, 32'hB2000000, 1, 4'b1000, 4'b0000, 0, 9'h0B2);
    tbl[10] = mk(4'b1000, 4'b0000, 32'hB2000000, 1, 4'b1000, 4'b0000, 0, 9'h0B2);
    tbl[11] = mk(4'b1000, 4'b0000, 32'hB2000000, 0, 4'b1000, 4'b1000, 1, 9'h0B2);
    tbl[12] = mk(4'b1000, 4'b1000, 32'hB3000000, 0, 4'b1000, 4'b1000, 1, 9'h1B3);
    tbl[13] = mk(4'b0000, 4'b0000, 32'h00000000, 0, 4'b0000, 4'b0000, 0, 9'h000);

    rrst_n = 1'b0;
    m_valid = '0; m_last = '0; m_data = '0; m_wfull = 1'b0;
    t_valid = '0; t_last = '0; t_data = '0; t_wfull = 1'b0;
    n_valid = '0; n_last = '0; n_data = '0; n_wfull = 1'b0;

    // reset values
    @(negedge wclk);
    chk("rst grant", 32'(m_grant), 32'h0);
    chk("rst ready", 32'(m_ready), 32'h0);
    chk("rst winc",  32'(m_winc),  32'h0);
    chk("rst wdata", 32'(m_wdata), 32'h0);
    chk("rst busy",  32'(m_busy),  32'h0);
    chk("rst fcnt",  32'(m_fcnt),  32'h0);
    chk("rst tcnt",  32'(m_tcnt),  32'h0);
    nxt();
    rrst_n = 1'b1;

    // cycle table
    for (int k = 0; k < 14; k++) begin
      m_valid = tbl[k].v; m_last = tbl[k].l; m_data = tbl[k].d; m_wfull = tbl[k].f;
      @(negedge wclk);
      chk($sformatf("v%0d grant", k), 32'(m_grant), 32'(tbl[k].eg));
      chk($sformatf("v%0d ready", k), 32'(m_ready), 32'(tbl[k].er));
      chk($sformatf("v%0d winc",  k), 32'(m_winc),  32'(tbl[k].ew));
      chk($sformatf("v%0d wdata", k), 32'(m_wdata), 32'(tbl[k].ewd));
      nxt();
    end
    chk("tbl fcnt", 32'(m_fcnt), 32'd2);
    chk("tbl tcnt", 32'(m_tcnt), 32'd0);

    // all requesters valid, 2-beat frames: expect owners 0,1,2,3,0
    m_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      m_last = 4'b0000;
      for (int i = 0; i < 4; i++) m_data[i*8 +: 8] = 8'(16*(i+1));
      @(negedge wclk);
      chk($sformatf("rr%0d gap grant", f), 32'(m_grant), 32'h0);
      chk($sformatf("rr%0d gap busy", f),  32'(m_busy),  32'h0);
      nxt();
      @(negedge wclk);
      chk($sformatf("rr%0d grant", f),  32'(m_grant), 32'(1 << (f % 4)));
      chk($sformatf("rr%0d b0 winc", f), 32'(m_winc),  32'h1);
      chk($sformatf("rr%0d b0 data", f), 32'(m_wdata), 32'(16*((f%4)+1)));
      nxt();
      m_last = 4'b1111;
      for (int i = 0; i < 4; i++) m_data[i*8 +: 8] = 8'(16*(i+1) + 1);
      @(negedge wclk);
      chk($sformatf("rr%0d b1 grant", f), 32'(m_grant), 32'(1 << (f % 4)));
      chk($sformatf("rr%0d b1 winc", f),  32'(m_winc),  32'h1);
      chk($sformatf("rr%0d b1 data", f),  32'(m_wdata), 32'h100 | 32'(16*((f%4)+1) + 1));
      nxt();
    end
    m_valid = '0; m_last = '0;
    chk("rr fcnt", 32'(m_fcnt), 32'd7);

    // truncation at MAXLEN=4: requester 2 sends 7 beats
    t_valid = 4'b0100;
    @(negedge wclk);
    chk("trn idle grant", 32'(t_grant), 32'h0);
    nxt();
    for (int k = 1; k <= 7; k++) begin
      t_data  = 32'(8'hC0 + k) << 16;
      t_last  = (k == 7) ? 4'b0100 : 4'b0000;
      t_wfull = (k == 6);
      @(negedge wclk);
      chk($sformatf("trn b%0d ready", k), 32'(t_ready), 32'h4);
      chk($sformatf("trn b%0d winc", k),  32'(t_winc),  (k <= 4) ? 32'h1 : 32'h0);
      chk($sformatf("trn b%0d busy", k),  32'(t_busy),  32'h1);
      if (k <= 4)
        chk($sformatf("trn b%0d data", k), 32'(t_wdata),
            ((k == 4) ? 32'h100 : 32'h0) | 32'(8'hC0 + k));
      nxt();
    end
    t_valid = '0; t_last = '0; t_wfull = 1'b0;
    @(negedge wclk);
    chk("trn end grant", 32'(t_grant), 32'h0);
    chk("trn end busy",  32'(t_busy),  32'h0);
    chk("trn tcnt",      32'(t_tcnt),  32'd1);
    chk("trn fcnt",      32'(t_fcnt),  32'd1);
    nxt();

    // NREQ=3: after requester 2, requester 0 wins over 1
    n_valid = 3'b100; n_last = 3'b100; n_data = 24'hD10000;
    nxt();
    @(negedge wclk);
    chk("n3 r2 grant", 32'(n_grant), 32'h4);
    chk("n3 r2 winc",  32'(n_winc),  32'h1);
    chk("n3 r2 data",  32'(n_wdata), 32'h1D1);
    nxt();
    n_valid = 3'b011; n_last = 3'b011; n_data = 24'h00E1E0;
    @(negedge wclk);
    chk("n3 gap grant", 32'(n_grant), 32'h0);
    nxt();
    @(negedge wclk);
    chk("n3 r0 grant", 32'(n_grant), 32'h1);
    chk("n3 r0 data",  32'(n_wdata), 32'h1E0);
    nxt();
    n_valid = 3'b010;
    @(negedge wclk);
    chk("n3 gap2 grant", 32'(n_grant), 32'h0);
    nxt();
    @(negedge wclk);
    chk("n3 r1 grant", 32'(n_grant), 32'h2);
    chk("n3 r1 data",  32'(n_wdata), 32'h1E1);
    nxt();
    n_valid = '0; n_last = '0;
    chk("n3 fcnt", 32'(n_fcnt), 32'd3);

    // reset during beat 2 of a requester-1 frame (pointer is 1 here)
    m_valid = 4'b0010; m_last = 4'b0000; m_data = 32'h0000F100;
    nxt();
    @(negedge wclk);
    chk("rm b1 winc", 32'(m_winc), 32'h1);
    nxt();
    m_data = 32'h0000F200;
    #2;
    rrst_n = 1'b0;
    #1;
    chk("rm grant", 32'(m_grant), 32'h0);
    chk("rm ready", 32'(m_ready), 32'h0);
    chk("rm winc",  32'(m_winc),  32'h0);
    chk("rm busy",  32'(m_busy),  32'h0);
    chk("rm fcnt",  32'(m_fcnt),  32'h0);
    nxt();
    rrst_n = 1'b1;
    m_valid = 4'b0011; m_last = 4'b0011; m_data = 32'h00005150;
    @(negedge wclk);
    chk("rm idle grant", 32'(m_grant), 32'h0);
    nxt();
    @(negedge wclk);
    chk("rm first grant", 32'(m_grant), 32'h1);
    chk("rm first data",  32'(m_wdata), 32'h150);
    nxt();
    m_valid = '0; m_last = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_sched.md
# fifo_wr_sched

Frame-granular round-robin scheduler that shares the single write port of the asynchronous MII-side FIFO among up to NREQ byte-stream requesters. It grants one requester at a time, holds the grant until that requester's end-of-frame, and applies backpressure from the FIFO full flag. It enforces a maximum frame length by truncation. It sits in the wclk domain directly in front of the FIFO write side.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, data byte width
- MAXLEN, 1518, maximum beats per frame; beat MAXLEN is forced to carry last
- wclk  in  1  write-domain clock; all logic on its rising edge
- rrst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW]
- req_last  in  NREQ  per-requester end-of-frame marker, qualified by valid
- req_ready  out  NREQ  per-requester beat accept
- fifo_winc  out  1  FIFO write enable
- fifo_wdata  out  DW+1  {last, data} written to the FIFO
- fifo_wfull  in  1  FIFO full flag; combinational from the FIFO, same cycle
- grant  out  NREQ  one-hot current owner; 0 when idle
- busy  out  1  high in XFER or DRAIN
- frame_cnt  out  16  frames completed, wraps
- trunc_cnt  out  16  frames truncated, saturates at 16'hFFFF

## Operation
- States:
  - IDLE: grant=0, no ready. If any req_valid, select the first valid requester at or after rr_ptr (circular), register it into grant, then go to XFER.
  - XFER:
    - req_ready[g] = grant[g] & ~fifo_wfull.
    - fifo_winc = req_valid[g] & ~fifo_wfull.
    - fifo_wdata = {req_last[g] | (len == MAXLEN-1), req_data[g]}.
    - len counts accepted beats.
  - End of XFER:
    - Accepted beat with req_last: frame_cnt+1, rr_ptr = g+1 mod NREQ, go to IDLE.
    - Accepted beat at len == MAXLEN-1 without req_last: last is forced, frame_cnt+1, trunc_cnt+1, go to DRAIN.
  - DRAIN:
    - req_ready[g]=1 regardless of fifo_wfull; fifo_winc=0; the remaining beats are discarded.
    - On an accepted req_last: rr_ptr = g+1, go to IDLE.
- Requests from non-granted requesters are never accepted.
- req_valid is never dropped by the scheduler. A requester that deasserts valid mid-frame stalls XFER indefinitely; there is no timeout.
- Width rules:
  - len is $clog2(MAXLEN+1) bits, cleared on IDLE→XFER.
  - rr_ptr is $clog2(NREQ) bits.
  - When NREQ is not a power of two, rr_ptr wraps explicitly at NREQ-1→0.
- Reset mid-frame: all state is cleared immediately and outputs go to their reset values. No terminating beat is written to the FIFO. Recovery is the FIFO side's responsibility, since it shares rrst_n.

## Timing
- Reset values: grant=0, req_ready=0, fifo_winc=0, fifo_wdata=0, busy=0, frame_cnt=0, trunc_cnt=0. Internally, state=IDLE, rr_ptr=0, len=0.
- Arbitration latency: req_valid is seen in IDLE at cycle n, grant is registered at n+1, and the first fifo_winc is possible at n+1.
- Inter-frame gap: one IDLE cycle minimum between consecutive frames, including back-to-back frames from the same requester.
- Backpressure: ready and winc are combinational from registered grant, req_valid and fifo_wfull. When fifo_wfull=1, no beat is accepted or written that cycle.
- A single-beat frame whose only beat has last=1 spends one cycle in XFER.
- MAXLEN=1 gives truncation on beat 1 whenever last=0.

## Structure
- Shared package: state encoding (IDLE, XFER, DRAIN); LAST_BIT index = DW in the FIFO word; counter widths.
- One sub-module: rr_pick. It is combinational: it takes the valid vector and rr_ptr and returns a one-hot pick plus an any-valid flag.
- The state register, len, counters and datapath mux live in fifo_wr_sched.

## Test plan
- Single requester 1, 4-byte frame 0xA1..0xA4 with last on 0xA4, fifo_wfull=0.
  - Required: grant=4'b0010 one cycle after valid, 4 fifo_winc pulses, fifo_wdata 0x0A1,0x0A2,0x0A3,0x1A4, frame_cnt=1.
- All 4 requesters continuously valid with 2-beat frames.
  - Required: grants go 0,1,2,3,0; one idle cycle between frames; no interleaving of beats.
- fifo_wfull=1 for 3 cycles mid-frame.
  - Required: req_ready=0 and fifo_winc=0 for exactly those cycles; data order preserved; no beat lost or duplicated.
- MAXLEN=4, requester 2 sends a 7-beat frame.
  - Required: 4 FIFO writes, the 4th with bit DW=1; 3 beats accepted in DRAIN with winc=0; trunc_cnt=1, frame_cnt=1.
- rrst_n asserted during beat 2 of a frame.
  - Required: grant, ready, winc and busy go 0 asynchronously; after release, requester 0 is granted first.
- NREQ=3, rr_ptr wrap.
  - Required: after requester 2 completes, requester 0 is granted before requester 1 when both are valid.
